// File: rtl/imm_pipe_gen_if.sv
// Handshake bundle for imm_pipe_gen: instruction input side and extended-immediate output side.
// slave = the generator itself, master = the decoder / register-read environment.
interface imm_pipe_gen_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    // Valid/ready on both sides: a transfer happens on a rising edge where valid & ready are both 1;
    // a producer holds its payload stable while valid = 1 and ready = 0.
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic              out_fmt;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
    );
endinterface

// File: rtl/imm_pipe_gen.sv
// Decode-stage immediate generator: format decode, sign extension and a 2-entry output buffer.
// Optional macro IMM_BR_SHIFT_EN scales B-format immediates by 4 (byte offset) before extension.
module imm_pipe_gen #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_pipe_gen_if.slave       pipe_if,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [XLEN-1:0]    head_imm_q;
    logic               head_fmt_q;
    logic [TAG_W-1:0]   head_tag_q;
    logic [XLEN-1:0]    tail_imm_q;
    logic               tail_fmt_q;
    logic [TAG_W-1:0]   tail_tag_q;

    logic [4:0]         opcode_w;
    logic               is_b_w;
    logic [15:0]        field_w;
    logic [XLEN-1:0]    imm_d;
    logic               push_w;
    logic               pop_w;
    logic               unused_instr_w;

    assign opcode_w       = pipe_if.in_instr[31:27];
    assign is_b_w         = (opcode_w >= 5'b10000) && (opcode_w <= 5'b10100);
    assign field_w        = is_b_w ? pipe_if.in_instr[26:11] : pipe_if.in_instr[19:4];
    assign unused_instr_w = ^pipe_if.in_instr[3:0];

`ifdef IMM_BR_SHIFT_EN
    // Scaling keeps field bit 15 as the sign; the cast then extends or truncates to XLEN.
    logic [17:0] scaled_w;
    assign scaled_w = is_b_w ? {field_w, 2'b00} : {{2{field_w[15]}}, field_w};
    assign imm_d    = XLEN'($signed(scaled_w));
`else
    assign imm_d    = XLEN'($signed(field_w));
`endif

    assign push_w = pipe_if.in_valid & in_ready_q;
    assign pop_w  = out_valid_q & pipe_if.out_ready;

    // in_ready/out_valid are registered alongside the state, so out_ready never reaches in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_imm_q  <= '0;
            head_fmt_q  <= 1'b0;
            head_tag_q  <= '0;
            tail_imm_q  <= '0;
            tail_fmt_q  <= 1'b0;
            tail_tag_q  <= '0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_w) begin
                        head_imm_q  <= imm_d;
                        head_fmt_q  <= is_b_w;
                        head_tag_q  <= pipe_if.in_tag;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push_w && pop_w) begin
                        head_imm_q <= imm_d;
                        head_fmt_q <= is_b_w;
                        head_tag_q <= pipe_if.in_tag;
                    end else if (push_w) begin
                        tail_imm_q <= imm_d;
                        tail_fmt_q <= is_b_w;
                        tail_tag_q <= pipe_if.in_tag;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop_w) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop_w) begin
                        head_imm_q <= tail_imm_q;
                        head_fmt_q <= tail_fmt_q;
                        head_tag_q <= tail_tag_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_if.in_ready  = in_ready_q;
    assign pipe_if.out_valid = out_valid_q;
    assign pipe_if.out_imm   = head_imm_q;
    assign pipe_if.out_fmt   = head_fmt_q;
    assign pipe_if.out_tag   = head_tag_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_imm_pipe_gen.sv
// Scoreboarded bench for imm_pipe_gen: directed cases plus randomized traffic with random back-pressure.
module tb_imm_pipe_gen;
    localparam int XLEN  = 32;
    localparam int TAG_W = 8;
    localparam int EW    = XLEN + 1 + TAG_W;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] state_dbg;

    imm_pipe_gen_if #(.XLEN(XLEN), .TAG_W(TAG_W)) pipe_if ();

    imm_pipe_gen #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .pipe_if (pipe_if),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    bit rnd_done = 1'b0;

    // Reference: pick the field by opcode range, treat it as a signed 16-bit number, scale, truncate.
    function automatic logic [EW-1:0] model(input logic [31:0] instr, input logic [TAG_W-1:0] tag);
        int unsigned op;
        bit          b;
        longint      f;
        logic [63:0] fv;
        op = int'(instr >> 27);
        b  = (op >= 16) && (op <= 20);
        f  = b ? longint'((instr >> 11) & 32'hFFFF) : longint'((instr >> 4) & 32'hFFFF);
        if (f >= 32768) f = f - 65536;
`ifdef IMM_BR_SHIFT_EN
        if (b) f = f * 4;
`endif
        fv = f;
        return {fv[XLEN-1:0], b, tag};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [TAG_W-1:0] tag);
        bit acc = 1'b0;
        pipe_if.in_valid = 1'b1;
        pipe_if.in_instr = instr;
        pipe_if.in_tag   = tag;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            if (pipe_if.in_ready) begin
                acc = 1'b1;
                if (!flush) exp_q.push_back(model(instr, tag));
            end
            @(posedge clk);
            #1;
        end
        pipe_if.in_valid = 1'b0;
        check("send_accepted", {63'd0, acc}, 64'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops and compares on every output transfer, and checks head stability under stall.
    initial begin : monitor
        bit            stall;
        logic [EW-1:0] held;
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            got = {pipe_if.out_imm, pipe_if.out_fmt, pipe_if.out_tag};
            if (stall && pipe_if.out_valid) check("hold_stable", 64'(got), 64'(held));
            if (pipe_if.out_valid && pipe_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", got);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_entry", 64'(got), 64'(exp));
                end
            end
            stall = pipe_if.out_valid && !pipe_if.out_ready;
            held  = got;
            if (flush) begin
                exp_q.delete();
                stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [EW-1:0] e;
        logic [31:0]   r;
        logic [4:0]    op;

        pipe_if.in_valid  = 1'b1;
        pipe_if.in_instr  = 32'h70080010;
        pipe_if.in_tag    = '0;
        pipe_if.out_ready = 1'b0;

        // Reset held with in_valid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(pipe_if.in_ready), 64'd1);
        check("reset_out_valid", 64'(pipe_if.out_valid), 64'd0);
        check("reset_out_imm", 64'(pipe_if.out_imm), 64'd0);
        check("reset_out_fmt", 64'(pipe_if.out_fmt), 64'd0);
        check("reset_out_tag", 64'(pipe_if.out_tag), 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        pipe_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // I-format directed vector
        send(32'h70080010, 8'h3C);
        check("i_valid", 64'(pipe_if.out_valid), 64'd1);
        check("i_imm", 64'(pipe_if.out_imm), 64'hFFFF8001);
        check("i_fmt", 64'(pipe_if.out_fmt), 64'd0);
        check("i_tag", 64'(pipe_if.out_tag), 64'h3C);
        cycles(1);
        pipe_if.out_ready = 1'b1;
        cycles(1);
        check("i_drained", 64'(pipe_if.out_valid), 64'd0);
        pipe_if.out_ready = 1'b0;

        // B-format directed vector
        send(32'h88002000, 8'h5A);
`ifdef IMM_BR_SHIFT_EN
        check("b_imm", 64'(pipe_if.out_imm), 64'h10);
`else
        check("b_imm", 64'(pipe_if.out_imm), 64'h4);
`endif
        check("b_fmt", 64'(pipe_if.out_fmt), 64'd1);
        pipe_if.out_ready = 1'b1;
        cycles(1);
        pipe_if.out_ready = 1'b0;

        // Back-pressure: two accepts, third held off, then all three in order
        send(32'h0000FFF0, 8'h01);
        send(32'h80040000, 8'h02);
        check("bp_in_ready_low", 64'(pipe_if.in_ready), 64'd0);
        check("bp_state_full", 64'(state_dbg), 64'd2);
        pipe_if.in_valid = 1'b1;
        pipe_if.in_instr = 32'hA0123450;
        pipe_if.in_tag   = 8'h03;
        repeat (3) begin
            @(negedge clk);
            check("bp_third_held", 64'(pipe_if.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        pipe_if.out_ready = 1'b1;
        send(32'hA0123450, 8'h03);
        cycles(3);
        check("bp_all_out", 64'(exp_q.size()), 64'd0);
        check("bp_empty", 64'(pipe_if.out_valid), 64'd0);

        // Simultaneous push and pop while holding one entry
        send(32'h00012340, 8'h10);
        send(32'h98765430, 8'h11);
        e = model(32'h98765430, 8'h11);
        check("pp_valid", 64'(pipe_if.out_valid), 64'd1);
        check("pp_state_one", 64'(state_dbg), 64'd1);
        check("pp_head_imm", 64'(pipe_if.out_imm), 64'(e[EW-1 -: XLEN]));
        check("pp_head_tag", 64'(pipe_if.out_tag), 64'h11);
        cycles(1);
        check("pp_drained", 64'(pipe_if.out_valid), 64'd0);

        // Flush in FULL with a concurrent push that must be dropped
        pipe_if.out_ready = 1'b0;
        send(32'h11111110, 8'h20);
        send(32'h82222220, 8'h21);
        pipe_if.in_valid = 1'b1;
        pipe_if.in_instr = 32'h0DEAD0E0;
        pipe_if.in_tag   = 8'hEE;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        pipe_if.in_valid = 1'b0;
        check("flush_out_valid", 64'(pipe_if.out_valid), 64'd0);
        check("flush_in_ready", 64'(pipe_if.in_ready), 64'd1);
        pipe_if.out_ready = 1'b1;
        cycles(4);
        check("flush_no_ghost", 64'(pipe_if.out_valid), 64'd0);

        // Flush in ONE with a pop in the same cycle
        send(32'h00ABC000, 8'h30);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        check("flush_pop_empty", 64'(pipe_if.out_valid), 64'd0);
        check("flush_pop_q", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-transfer
        pipe_if.out_ready = 1'b0;
        send(32'h12345670, 8'h40);
        send(32'h87654320, 8'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 64'(pipe_if.out_valid), 64'd0);
        check("areset_in_ready", 64'(pipe_if.in_ready), 64'd1);
        check("areset_out_imm", 64'(pipe_if.out_imm), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);

        // Randomized traffic with random back-pressure
        fork
            begin
                for (int n = 0; n < 250; n++) begin
                    r  = $urandom();
                    op = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(16, 20))
                                                     : 5'($urandom_range(0, 31));
                    send({op, r[26:0]}, 8'($urandom_range(0, 255)));
                    cycles($urandom_range(0, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    pipe_if.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        pipe_if.out_ready = 1'b1;
        cycles(5);
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_out_valid", 64'(pipe_if.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_pipe_gen.md
# imm_pipe_gen

Pipelined, parametrised immediate generator for the decode stage. It accepts 32-bit instructions over a valid/ready handshake and extracts the 16-bit immediate field according to the opcode format. It sign-extends the field to XLEN and carries a tag alongside. Results leave through a 2-entry output buffer, so the decoder and the register-read stage are decoupled at full throughput.

## Interface
Parameters:
- XLEN, 32: output immediate width; legal range 16..64.
- TAG_W, 8: width of the sideband tag (PC index or ROB id) passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all buffered entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word; opcode is [31:27].
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  1  format of the head entry; 0 = I-format, 1 = B-format.
- out_tag  out  TAG_W  tag of the head entry.

## Operation
Format decode (combinational, on in_instr):
- B-format applies to opcodes 10000, 10001, 10010, 10011 and 10100. The field is in_instr[26:11].
- I-format applies to every other opcode, including 01110 (ld/st) and 01111 (jmp). The field is in_instr[19:4].

Extension:
- The 16-bit field is sign-extended to XLEN, i.e. bit 15 is replicated into bits XLEN-1..16.
- When XLEN = 16 the field is output unmodified.

Buffer:
- Two entries, each holding {imm, fmt, tag}.
- The buffer is written on push = in_valid & in_ready.
- The buffer is read on pop = out_valid & out_ready.

State machine, on an occupancy count:
- EMPTY (0): push goes to ONE.
- ONE (1): push without pop goes to FULL. Pop without push goes to EMPTY. Push and pop together stay in ONE, with the new entry becoming the head.
- FULL (2): pop goes to ONE. A push is impossible in FULL because in_ready = 0.

Outputs:
- in_ready = (state != FULL). It is driven from registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_imm, out_fmt and out_tag come from the head entry. When out_valid = 0 they hold their last values.

Flush:
- flush = 1 forces EMPTY at the next edge. Any push in the same cycle is dropped.
- The pop in the flush cycle still counts as consumed.

## Timing
- Reset values: state EMPTY, so in_ready = 1 and out_valid = 0. out_imm = 0, out_fmt = 0 and out_tag = 0; all entry storage is cleared.
- Reset is asynchronous. Asserting rst_n low mid-transfer discards all entries immediately.
- Latency: an instruction accepted at edge N appears on the outputs with out_valid = 1 after edge N, i.e. one cycle.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Back-pressure: with out_ready = 0, two instructions are accepted, then in_ready drops. in_ready returns to 1 in the cycle after the first pop.
- Outputs are stable while out_valid = 1 and out_ready = 0.
- Ordering: entries leave strictly in acceptance order.

## Configuration
- Macro IMM_BR_SHIFT_EN.
- When defined: the B-format immediate is shifted left by 2 before sign extension, giving a byte offset. The sign bit is the field's bit 15, and the result is truncated to XLEN. I-format is unaffected.
- When undefined: B-format is sign-extended only, giving a word offset.

## Test plan
- Reset: hold rst_n = 0 and drive in_valid = 1. Require in_ready = 1, out_valid = 0 and out_imm = 0, with no entries stored.
- I-format: send in_instr = 0x70080010 with tag 0x3C. After one edge require out_imm = 0xFFFF8001, out_fmt = 0 and out_tag = 0x3C.
- B-format: send in_instr = 0x88002000. Without the macro require out_imm = 0x00000004 and out_fmt = 1. With IMM_BR_SHIFT_EN require out_imm = 0x00000010.
- Back-pressure: hold out_ready = 0 and stream 3 instructions. Require in_ready = 0 after 2 accepts and the third held off. Then raise out_ready and require all 3 out in order.
- Simultaneous push and pop in ONE: require the count to stay at 1 and the new entry to appear at the head the next cycle, with the old entry consumed.
- Flush: in FULL, assert flush together with in_valid = 1. Require out_valid = 0 and in_ready = 1 next cycle, and require that the dropped instruction never appears.
